branch_flush_controller: RTL and testbench

- Central pipeline sequencer for the SPARC-style 5-stage core.
- Decides each cycle whether the PC and IF/ID register advance, stall or flush, and selects the next-PC source.
- Handles delayed-branch annulment, load-use stalls and trap entry with pipeline drain.
- Generates a stretched pipeline reset after system reset.
- Sits beside the PC/IF/ID/EX pipeline registers and drives their enable, flush and bubble controls.

---
 rtl/branch_flush_controller.sv | 147 ++++++++++++++
 tb/tb_branch_flush_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_flush_controller.sv
// Pipeline sequencer for the 5-stage core: PC/IF/ID advance, stall and flush control,
// next-PC source selection, trap entry with drain, and stretched pipeline reset.
module branch_flush_controller #(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned TRAP_DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W             = 8
) (
  input  logic             clk,
  input  logic             system_reset_n,
  input  logic             ID_branch_instr,
  input  logic             a,
  input  logic             branch_taken,
  input  logic             branch_always,
  input  logic             load_use_hazard,
  input  logic             trap_req,
  output logic             pipeline_reset,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       pc_sel,
  output logic             trap_ack,
  output logic [CNT_W-1:0] annul_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] PcSeq  = 2'b00;
  localparam logic [1:0] PcBr   = 2'b01;
  localparam logic [1:0] PcTrap = 2'b10;

  localparam logic [3:0] HoldInit  = 4'(RESET_HOLD_CYCLES - 1);
  localparam logic [3:0] DrainInit = 4'(TRAP_DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StHold, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       drain_q, drain_d;
  logic             trap_ack_q, trap_ack_d;
  logic [CNT_W-1:0] annul_q, annul_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Annul the delay slot of an untaken branch, or of BA, when the a bit is set.
  logic annul;
  assign annul = a & (~branch_taken | branch_always);

  // State and counter registers; reset forces HOLD and clears all event state.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q    <= StHold;
      hold_q     <= HoldInit;
      drain_q    <= '0;
      trap_ack_q <= 1'b0;
      annul_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
      trap_ack_q <= trap_ack_d;
      annul_q    <= annul_d;
      stall_q    <= stall_d;
    end
  end

  // Next-state, down-counters, trap acknowledge and saturating event counters.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    drain_d    = drain_q;
    trap_ack_d = 1'b0;
    annul_d    = annul_q;
    stall_d    = stall_q;
    case (state_q)
      StHold: begin
        if (hold_q == 4'd0) state_d = StRun;
        else                hold_d  = hold_q - 4'd1;
      end
      StRun: begin
        if (trap_req) begin
          state_d = StDrain;
          drain_d = DrainInit;
        end else if (load_use_hazard) begin
          if (stall_q != CntMax) stall_d = stall_q + 1'b1;
        end else if (ID_branch_instr && annul) begin
          if (annul_q != CntMax) annul_d = annul_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          state_d    = StRun;
          trap_ack_d = 1'b1;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // Pipeline controls; Mealy in RUN, fixed in HOLD and DRAIN.
  always_comb begin
    pipeline_reset = 1'b0;
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pc_sel         = PcSeq;
    case (state_q)
      StHold: begin
        pipeline_reset = 1'b1;
        pc_enable      = 1'b0;
        if_id_enable   = 1'b0;
      end
      StRun: begin
        if (trap_req) begin
          pc_sel       = PcTrap;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use_hazard) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (ID_branch_instr) begin
          pc_sel      = branch_taken ? PcBr : PcSeq;
          if_id_flush = annul;
        end
      end
      StDrain: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: begin
        pipeline_reset = 1'b1;
        pc_enable      = 1'b0;
        if_id_enable   = 1'b0;
      end
    endcase
  end

  assign trap_ack    = trap_ack_q;
  assign annul_count = annul_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_branch_flush_controller.sv
// Directed bench for branch_flush_controller with default parameters.
module tb_branch_flush_controller;

  logic       clk = 1'b0;
  logic       system_reset_n;
  logic       ID_branch_instr, a, branch_taken, branch_always, load_use_hazard, trap_req;
  logic       pipeline_reset, pc_enable, if_id_enable, if_id_flush, id_ex_bubble, trap_ack;
  logic [1:0] pc_sel;
  logic [7:0] annul_count, stall_count;

  int total = 0;
  int bad   = 0;

  branch_flush_controller #(
    .RESET_HOLD_CYCLES(2),
    .TRAP_DRAIN_CYCLES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .system_reset_n(system_reset_n),
    .ID_branch_instr(ID_branch_instr),
    .a(a),
    .branch_taken(branch_taken),
    .branch_always(branch_always),
    .load_use_hazard(load_use_hazard),
    .trap_req(trap_req),
    .pipeline_reset(pipeline_reset),
    .pc_enable(pc_enable),
    .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .pc_sel(pc_sel),
    .trap_ack(trap_ack),
    .annul_count(annul_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    system_reset_n  = 1'b0;
    ID_branch_instr = 1'b0;
    a               = 1'b0;
    branch_taken    = 1'b0;
    branch_always   = 1'b0;
    load_use_hazard = 1'b0;
    trap_req        = 1'b0;

    // Reset state
    #3;
    chk("rst_prst", 8'(pipeline_reset), 8'd1);
    chk("rst_pcen", 8'(pc_enable), 8'd0);
    chk("rst_ifen", 8'(if_id_enable), 8'd0);
    chk("rst_ack", 8'(trap_ack), 8'd0);
    chk("rst_annul", annul_count, 8'd0);
    chk("rst_stall", stall_count, 8'd0);

    // Release; pipeline_reset spans two rising edges
    @(negedge clk);
    system_reset_n = 1'b1;
    @(negedge clk);
    chk("hold1_prst", 8'(pipeline_reset), 8'd1);
    chk("hold1_pcen", 8'(pc_enable), 8'd0);
    @(negedge clk);
    chk("run_prst", 8'(pipeline_reset), 8'd0);
    chk("run_pcen", 8'(pc_enable), 8'd1);
    chk("run_ifen", 8'(if_id_enable), 8'd1);
    chk("run_pcsel", 8'(pc_sel), 8'd0);

    // Bicc a=1 untaken: annul, sequential PC
    ID_branch_instr = 1'b1; a = 1'b1; branch_taken = 1'b0; branch_always = 1'b0;
    #1;
    chk("bnt_pcsel", 8'(pc_sel), 8'd0);
    chk("bnt_flush", 8'(if_id_flush), 8'd1);
    @(negedge clk);
    chk("bnt_annul", annul_count, 8'd1);

    // Bicc a=1 taken: delay slot executes
    branch_taken = 1'b1;
    #1;
    chk("bt_pcsel", 8'(pc_sel), 8'd1);
    chk("bt_flush", 8'(if_id_flush), 8'd0);
    @(negedge clk);
    chk("bt_annul", annul_count, 8'd1);

    // BA a=1: taken and annulled
    branch_always = 1'b1;
    #1;
    chk("ba_pcsel", 8'(pc_sel), 8'd1);
    chk("ba_flush", 8'(if_id_flush), 8'd1);
    @(negedge clk);
    chk("ba_annul", annul_count, 8'd2);

    // Load-use hazard masks the branch for one cycle
    branch_always = 1'b0; branch_taken = 1'b0; load_use_hazard = 1'b1;
    #1;
    chk("hz_pcen", 8'(pc_enable), 8'd0);
    chk("hz_ifen", 8'(if_id_enable), 8'd0);
    chk("hz_bubble", 8'(id_ex_bubble), 8'd1);
    chk("hz_pcsel", 8'(pc_sel), 8'd0);
    chk("hz_flush", 8'(if_id_flush), 8'd0);
    @(negedge clk);
    chk("hz_stall", stall_count, 8'd1);
    chk("hz_annul", annul_count, 8'd2);
    load_use_hazard = 1'b0;
    #1;
    chk("hz2_pcsel", 8'(pc_sel), 8'd0);
    chk("hz2_flush", 8'(if_id_flush), 8'd1);
    chk("hz2_pcen", 8'(pc_enable), 8'd1);
    @(negedge clk);
    chk("hz2_annul", annul_count, 8'd3);

    // Trap over an annulling branch
    trap_req = 1'b1;
    #1;
    chk("tr_pcsel", 8'(pc_sel), 8'd2);
    chk("tr_flush", 8'(if_id_flush), 8'd1);
    chk("tr_bubble", 8'(id_ex_bubble), 8'd1);
    chk("tr_pcen", 8'(pc_enable), 8'd1);
    @(negedge clk);
    chk("tr_annul", annul_count, 8'd3);
    ID_branch_instr = 1'b0; a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dr_pcen", 8'(pc_enable), 8'd0);
      chk("dr_bubble", 8'(id_ex_bubble), 8'd1);
      chk("dr_pcsel", 8'(pc_sel), 8'd0);
      chk("dr_ack", 8'(trap_ack), 8'd0);
      if (i == 2) trap_req = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("ack_hi", 8'(trap_ack), 8'd1);
    chk("ack_pcen", 8'(pc_enable), 8'd1);
    @(negedge clk);
    chk("ack_lo", 8'(trap_ack), 8'd0);

    // Reset pulse during DRAIN
    trap_req = 1'b1;
    @(negedge clk);
    trap_req = 1'b0;
    #1;
    chk("dr2_pcen", 8'(pc_enable), 8'd0);
    system_reset_n = 1'b0;
    #1;
    chk("mrst_prst", 8'(pipeline_reset), 8'd1);
    chk("mrst_bubble", 8'(id_ex_bubble), 8'd0);
    chk("mrst_ack", 8'(trap_ack), 8'd0);
    chk("mrst_annul", annul_count, 8'd0);
    chk("mrst_stall", stall_count, 8'd0);
    @(negedge clk);
    system_reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_hold", 8'(pipeline_reset), 8'd1);
    @(negedge clk);
    chk("mrst_run", 8'(pipeline_reset), 8'd0);

    // 300 annulled branches saturate the counter
    ID_branch_instr = 1'b1; a = 1'b1; branch_taken = 1'b0;
    repeat (300) @(negedge clk);
    chk("sat_annul", annul_count, 8'd255);
    chk("sat_stall", stall_count, 8'd0);
    ID_branch_instr = 1'b0; a = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
